// File: rtl/integral_pkg.sv
// Shared sizing, types and row-index helpers for the streaming integral image / box-sum block.
// Change the frame geometry here; every other file derives its widths from these values.
package integral_pkg;
  localparam int PIX_W = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int WIN   = 3;
  localparam int SUM_W = PIX_W + $clog2(IMG_W * IMG_H + 1);
  localparam int X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int R_W   = (WIN > 1) ? $clog2(WIN) : 1;

  typedef logic [SUM_W-1:0] sum_t;
  typedef logic [X_W-1:0]   x_t;
  typedef logic [Y_W-1:0]   y_t;
  typedef logic [R_W-1:0]   r_t;

  typedef struct packed {
    sum_t s;
    sum_t box_sum;
    logic box_valid;
    x_t   out_x;
    y_t   out_y;
    logic out_eof;
  } ii_result_t;

  // Row-buffer slots are used cyclically modulo WIN.
  function automatic r_t row_next(input r_t r);
    return (r == r_t'(WIN - 1)) ? '0 : r + r_t'(1);
  endfunction

  function automatic r_t row_prev(input r_t r);
    return (r == '0) ? r_t'(WIN - 1) : r - r_t'(1);
  endfunction
endpackage

// File: rtl/integral_image_box_row_buffer.sv
// WIN x IMG_W store of integral values, one slot per row modulo WIN.
// Reads are combinational, so the current-row read sees the old value in the cycle it is overwritten.
module ii_row_buffer
  import integral_pkg::*;
(
  input  logic clock,
  input  r_t   up_row,
  input  x_t   col,
  output sum_t up_data,
  input  r_t   cur_row,
  output sum_t cur_data,
  input  logic wr_en,
  input  r_t   wr_row,
  input  x_t   wr_col,
  input  sum_t wr_data
);
  sum_t mem [WIN][IMG_W];

  assign up_data  = mem[up_row][col];
  assign cur_data = mem[cur_row][col];

  // Not reset: row 0 never consumes previous-row data, so stale contents are harmless.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_row][wr_col] <= wr_data;
  end
endmodule

// File: rtl/integral_image_box.sv
// Streaming integral image with WIN x WIN box sums; one result per accepted pixel, 1-cycle latency.
// Handshake: a transfer happens when valid && ready; in_ready = !out_valid || out_ready, so a stalled output freezes everything.
module integral_image_box
  import integral_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] new_sample,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] S,
  output logic [SUM_W-1:0] box_sum,
  output logic             box_valid,
  output logic [X_W-1:0]   out_x,
  output logic [Y_W-1:0]   out_y,
  output logic             out_eof
);
  x_t         x_cnt;
  y_t         y_cnt;
  r_t         row_idx;
  sum_t       rowacc;
  sum_t       c_sr [WIN];
  sum_t       a_sr [WIN];
  ii_result_t res;

  logic fire;
  x_t   px;
  y_t   py;
  r_t   cur_row;
  r_t   up_row;
  sum_t up_data;
  sum_t cur_data;
  sum_t rowacc_next;
  sum_t ii;
  sum_t b_term;
  sum_t c_term;
  sum_t a_term;
  logic last_col;
  logic last_row;
  logic win_ok;

  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;

  // in_sof overrides the counters so a truncated frame is simply abandoned.
  assign px      = in_sof ? '0 : x_cnt;
  assign py      = in_sof ? '0 : y_cnt;
  assign cur_row = in_sof ? '0 : row_idx;
  assign up_row  = row_prev(cur_row);

  assign last_col = (px == x_t'(IMG_W - 1));
  assign last_row = (py == y_t'(IMG_H - 1));
  assign win_ok   = (int'(px) >= WIN - 1) && (int'(py) >= WIN - 1);

  ii_row_buffer u_row_buffer (
    .clock    (clock),
    .up_row   (up_row),
    .col      (px),
    .up_data  (up_data),
    .cur_row  (cur_row),
    .cur_data (cur_data),
    .wr_en    (fire),
    .wr_row   (cur_row),
    .wr_col   (px),
    .wr_data  (ii)
  );

  assign rowacc_next = ((px == '0) ? '0 : rowacc) + sum_t'(new_sample);
  assign ii          = rowacc_next + ((py == '0) ? '0 : up_data);
  // The slot being overwritten holds row y-WIN only once y >= WIN.
  assign b_term      = (int'(py) >= WIN) ? cur_data : '0;
  assign c_term      = (px == '0) ? '0 : c_sr[WIN-1];
  assign a_term      = (px == '0) ? '0 : a_sr[WIN-1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      row_idx <= '0;
      rowacc  <= '0;
      for (int i = 0; i < WIN; i++) begin
        c_sr[i] <= '0;
        a_sr[i] <= '0;
      end
    end else if (fire) begin
      rowacc  <= rowacc_next;
      c_sr[0] <= ii;
      a_sr[0] <= b_term;
      for (int i = 1; i < WIN; i++) begin
        c_sr[i] <= (px == '0) ? '0 : c_sr[i-1];
        a_sr[i] <= (px == '0) ? '0 : a_sr[i-1];
      end
      if (last_col) begin
        x_cnt <= '0;
        if (last_row) begin
          y_cnt   <= '0;
          row_idx <= '0;
        end else begin
          y_cnt   <= py + y_t'(1);
          row_idx <= row_next(cur_row);
        end
      end else begin
        x_cnt   <= px + x_t'(1);
        y_cnt   <= py;
        row_idx <= cur_row;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid <= 1'b0;
      res       <= '0;
    end else if (fire) begin
      out_valid     <= 1'b1;
      res.s         <= ii;
      res.box_sum   <= win_ok ? (ii - b_term - c_term + a_term) : '0;
      res.box_valid <= win_ok;
      res.out_x     <= px;
      res.out_y     <= py;
      res.out_eof   <= last_col && last_row;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign S         = res.s;
  assign box_sum   = res.box_sum;
  assign box_valid = res.box_valid;
  assign out_x     = res.out_x;
  assign out_y     = res.out_y;
  assign out_eof   = res.out_eof;
endmodule

// File: tb/tb_integral_image_box.sv
// Bench for integral_image_box: constant vector table, then handshake scenarios checked
// against a brute-force summation model through an expected-result queue.
module tb_integral_image_box;
  import integral_pkg::*;

  localparam int RW = 2 * SUM_W + 1 + X_W + Y_W + 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_sof = 1'b0;
  logic [PIX_W-1:0] new_sample = '0;
  logic             out_ready = 1'b1;
  logic             in_ready;
  logic             out_valid;
  logic [SUM_W-1:0] S;
  logic [SUM_W-1:0] box_sum;
  logic             box_valid;
  logic [X_W-1:0]   out_x;
  logic [Y_W-1:0]   out_y;
  logic             out_eof;

  integral_image_box dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .new_sample (new_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .S          (S),
    .box_sum    (box_sum),
    .box_valid  (box_valid),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_eof    (out_eof)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  logic [RW-1:0] exp_q[$];
  int  ready_mode = 0;
  bit  mon_en = 1'b0;
  bit  prev_stall = 1'b0;
  logic [RW-1:0] prev_out;
  int  mpix [IMG_H][IMG_W];
  int  mx = 0;
  int  my = 0;
  logic [SUM_W-1:0] last_eof_s = '0;
  logic [SUM_W-1:0] last_eof_box = '0;

  wire [RW-1:0] cur_out = {S, box_sum, box_valid, out_x, out_y, out_eof};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] pack(input int s, input int b, input bit bv,
                                         input int x, input int y, input bit eof);
    return {sum_t'(s), sum_t'(b), bv, x_t'(x), y_t'(y), eof};
  endfunction

  function automatic logic [PIX_W-1:0] pat(input int i);
    return ((i / IMG_W) % 2 == 0) ? PIX_W'(i % IMG_W + 1) : PIX_W'(i % IMG_W + 5);
  endfunction

  // ---------------- reference model: plain rectangle sums ----------------
  task automatic model_push(input int p, input bit sof);
    int s;
    int b;
    bit bv;
    if (sof) begin
      mx = 0;
      my = 0;
    end
    mpix[my][mx] = p;
    s = 0;
    for (int r = 0; r <= my; r++)
      for (int c = 0; c <= mx; c++) s += mpix[r][c];
    bv = (mx >= WIN - 1) && (my >= WIN - 1);
    b = 0;
    if (bv)
      for (int r = my - WIN + 1; r <= my; r++)
        for (int c = mx - WIN + 1; c <= mx; c++) b += mpix[r][c];
    exp_q.push_back(pack(s, b, bv, mx, my, (mx == IMG_W - 1) && (my == IMG_H - 1)));
    mx++;
    if (mx == IMG_W) begin
      mx = 0;
      my++;
      if (my == IMG_H) my = 0;
    end
  endtask

  // ---------------- downstream ready ----------------
  always @(posedge clock) begin
    #1;
    out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (mon_en) begin
      check("in_ready", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", cur_out, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %0h want none", cur_out);
        end else begin
          check("result", cur_out, exp_q.pop_front());
          if (out_eof) begin
            last_eof_s   = S;
            last_eof_box = box_sum;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = cur_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int p, input bit sof);
    int n = 0;
    in_valid   = 1'b1;
    new_sample = PIX_W'(p);
    in_sof     = sof;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end else begin
      @(posedge clock);
      model_push(p, sof);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input bit use_sof);
    for (int i = 0; i < IMG_W * IMG_H; i++) send(pat(i), use_sof && (i == 0));
    idle();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    mon_en   = 1'b0;
    reset    = 1'b0;
    idle();
    @(posedge clock);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    mx = 0;
    my = 0;
    prev_stall = 1'b0;
    mon_en = 1'b1;
  endtask

  typedef struct {
    logic [PIX_W-1:0] pix;
    int s;
    int box;
    bit bv;
  } vec_t;

  vec_t tab [IMG_W*IMG_H];
  int s_tab [16] = '{1, 3, 6, 10, 6, 14, 24, 36, 7, 17, 30, 46, 12, 28, 48, 72};

  initial begin
    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", {out_valid, S, box_sum, box_valid, out_x, out_y, out_eof}, 0);
    check("reset_in_ready", in_ready, 1'b1);
    reset = 1'b1;

    // table-driven frame with constant expectations
    for (int i = 0; i < 16; i++) begin
      tab[i].pix = pat(i);
      tab[i].s   = s_tab[i];
      tab[i].bv  = (i == 10) || (i == 11) || (i == 14) || (i == 15);
      case (i)
        10:      tab[i].box = 30;
        11:      tab[i].box = 39;
        14:      tab[i].box = 42;
        15:      tab[i].box = 51;
        default: tab[i].box = 0;
      endcase
    end
    for (int i = 0; i < 16; i++) begin
      in_valid   = 1'b1;
      in_sof     = (i == 0);
      new_sample = tab[i].pix;
      @(posedge clock);
      #1;
      check("table_valid", out_valid, 1'b1);
      check("table_vec", cur_out, pack(tab[i].s, tab[i].box, tab[i].bv, i % 4, i / 4, i == 15));
    end
    idle();
    @(posedge clock);
    #1;
    mon_en = 1'b1;

    // same frame under random backpressure
    ready_mode = 1;
    send_frame(1'b1);
    drain();

    // back-to-back frames, second all 255
    ready_mode = 0;
    send_frame(1'b1);
    for (int i = 0; i < IMG_W * IMG_H; i++) send(255, i == 0);
    idle();
    drain();
    check("frame2_final_s", last_eof_s, 4080);
    check("frame2_final_box", last_eof_box, 2295);

    // reset mid-frame, then a frame without sof
    ready_mode = 1;
    for (int i = 0; i < 6; i++) send(pat(i), i == 0);
    do_reset();
    send_frame(1'b0);
    drain();

    // sof on the third pixel restarts the frame
    send(pat(0), 1'b1);
    send(pat(1), 1'b0);
    send_frame(1'b1);
    drain();

    // random pixels, gaps and occasional sof
    for (int i = 0; i < 60; i++) begin
      send($urandom_range(0, 255), $urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
    end
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/integral_image_box.md
Name: integral_image_box

Overview:
- Streaming, parametrised successor of integral_image.
- Accepts a raster-order pixel stream with a valid/ready handshake and frame-start marker. Emits the integral image value II(x,y) for every pixel.
- Also emits a WIN×WIN box sum ending at (x,y) once the window fits inside the frame.
- Sits between the pixel source and feature/box-filter stages. Downstream does not need to buffer a full integral frame to obtain window sums.

Parameters:
- PIX_W, 8, pixel width (unsigned)
- IMG_W, 4, frame width in pixels
- IMG_H, 4, frame height in pixels
- WIN, 3, box window side; legal range 2..min(IMG_W,IMG_H)
- SUM_W, PIX_W+$clog2(IMG_W*IMG_H+1), width of integral and box sums

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  new_sample valid
- in_ready  out  1  block can accept new_sample this cycle
- in_sof  in  1  with in_valid: sample is pixel (0,0) of a new frame
- new_sample  in  PIX_W  pixel value, raster order
- out_valid  out  1  output registers hold a result
- out_ready  in  1  downstream accepts result
- S  out  SUM_W  integral value II(x,y)
- box_sum  out  SUM_W  sum of pixels in rows y-WIN+1..y, cols x-WIN+1..x
- box_valid  out  1  box_sum meaningful (x>=WIN-1 and y>=WIN-1)
- out_x  out  $clog2(IMG_W)  column of current result
- out_y  out  $clog2(IMG_H)  row of current result
- out_eof  out  1  result is last pixel of frame

Behaviour:
- Reset (reset==0 at rising edge) clears all outputs to 0: out_valid, S, box_sum, box_valid, out_x, out_y, out_eof. It also clears x/y counters and the row accumulator.
- Row-buffer memory is not cleared. Row 0 treats previous-row data as 0 by gating on y.
- Reset mid-frame discards the partial frame. The first accepted sample after reset is pixel (0,0).
- Handshake:
  - in_ready = !out_valid || out_ready.
  - A transfer occurs when in_valid && in_ready.
  - Latency is 1 cycle: a result appears in the cycle after its transfer.
  - While out_valid && !out_ready, all outputs hold stable and no state advances.
- Per accepted pixel p at (x,y):
  - rowacc = (x==0 ? 0 : rowacc) + p.
  - II = rowacc + (y==0 ? 0 : LB[(y-1) mod WIN][x]).
  - Write LB[y mod WIN][x] = II.
- Box sum: let D=II, B=II(x,y-WIN), C=II(x-WIN,y), A=II(x-WIN,y-WIN).
  - Terms with negative coordinates are 0.
  - box_sum = D - B - C + A, computed modulo 2^SUM_W; the true result is always non-negative and fits.
  - B is read from LB[y mod WIN][x] before the same-cycle overwrite (read-before-write required).
  - C comes from a WIN-deep shift register of the emitted II values; it is cleared at x==0.
  - A comes from a WIN-deep shift register of the B reads.
- box_valid=1 iff x>=WIN-1 and y>=WIN-1. When box_valid=0, box_sum is 0.
- Counters:
  - x increments per accepted pixel.
  - At x==IMG_W-1, x wraps to 0 and y increments.
  - At (IMG_W-1, IMG_H-1), out_eof=1 and both counters wrap to 0.
- in_sof with a transfer forces the pixel to (0,0) regardless of counters. Stale frame data is abandoned.
- Behaviour of in_sof without in_valid is ignored.
- Back-to-back frames need no idle cycle.
- Arithmetic is unsigned; no saturation is needed because SUM_W covers the full-frame maximum.

Decomposition:
- Package integral_pkg holds:
  - localparam helpers: coordinate widths, SUM_W formula
  - typedef sum_t (logic [SUM_W-1:0])
  - typedef struct ii_result_t {S, box_sum, box_valid, out_x, out_y, out_eof}
- One sub-module: ii_row_buffer, the WIN×IMG_W storage. It has one read port for row y-1, one read-before-write port for row y mod WIN, and one write port.
- The top level holds the counters, row accumulator, shift registers and the output stage.

Test Plan:
- Frame with rows {1,2,3,4},{5,6,7,8},{1,2,3,4},{5,6,7,8}, WIN=3, out_ready=1 -> S sequence:
  - row 0: 1,3,6,10
  - row 1: 6,14,24,36
  - row 2: 7,17,30,46
  - row 3: 12,28,48,72
  - out_eof only with 72.
- Same frame, box outputs:
  - box_valid only at (2,2),(3,2),(2,3),(3,3).
  - box_sum = 30, 39, 42, 51 respectively.
  - All other positions give box_valid=0 and box_sum=0.
- Random out_ready deassertion (~50%) on the same frame -> identical S/box_sum sequence. Outputs hold stable while stalled; in_ready low whenever out_valid && !out_ready.
- Two frames back-to-back, second all 8'd255 -> second frame final S=4080, box at (3,3)=2295. No contamination from frame 1.
- reset low for one cycle after 6 pixels, then the full frame -> out_valid=0 in the cycle after reset; the subsequent outputs match scenario 1 exactly.
- in_sof asserted on the 3rd pixel of a frame, then 16 pixels of the scenario-1 frame -> results restart at (0,0) and match scenario 1.
